// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer slice.
// Holds the FSM state encoding and the default word width.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit counter for the serializer: counts 0..WIDTH-1 and saturates.
// Ports: clk, rst (async active-low), clr, en, cnt, tc (cnt == WIDTH-1).
import piso_pkg::*;

module piso_bit_cnt #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input handshake.
// Ports: clk, rst (async active-low), din/din_valid/din_ready in,
//        sout/sout_valid/done registered out.
// Optional macro PISO_PARITY_EN appends an even-parity bit per word.
import piso_pkg::*;

module piso_serializer #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             xfer;
    logic             last_next;

`ifdef PISO_PARITY_EN
    logic             par;
`endif

    // done is high exactly in the final-bit cycle, which is also
    // the only non-idle cycle where a new word may be accepted.
    assign din_ready = (state == IDLE) | done;
    assign xfer      = din_valid & din_ready;

`ifdef PISO_PARITY_EN
    assign last_next = 1'b0;
`else
    assign last_next = (cnt == CW'(WIDTH - 2));
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (xfer),
        .en  (state == SHIFT),
        .cnt (cnt),
        .tc  (tc)
    );

    // The first bit is loaded into sout at the transfer edge, so sreg
    // always holds the not-yet-presented bits, pre-aligned at the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (xfer) begin
            state      <= SHIFT;
            sout       <= head(din);
            sreg       <= adv(din);
            sout_valid <= 1'b1;
            done       <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= ^din;
`endif
        end else begin
            unique case (state)
                SHIFT: begin
                    if (!tc) begin
                        sout <= head(sreg);
                        sreg <= adv(sreg);
                        done <= last_next;
                    end else begin
`ifdef PISO_PARITY_EN
                        state <= PAR;
                        sout  <= par;
                        done  <= 1'b1;
`else
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        done       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances in lockstep,
// scoreboard of expected {done,bit} pairs per lane.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic rdy_m, so_m, sv_m, dn_m;
    logic rdy_l, so_l, sv_l, dn_l;

    int total = 0;
    int bad   = 0;

    logic [1:0] qm[$];
    logic [1:0] ql[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_m),
        .sout       (so_m),
        .sout_valid (sv_m),
        .done       (dn_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_l),
        .sout       (so_l),
        .sout_valid (sv_l),
        .done       (dn_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
`ifdef PISO_PARITY_EN
            qm.push_back({1'b0, w[W-1-i]});
            ql.push_back({1'b0, w[i]});
`else
            qm.push_back({i == W - 1, w[W-1-i]});
            ql.push_back({i == W - 1, w[i]});
`endif
        end
`ifdef PISO_PARITY_EN
        qm.push_back({1'b1, ^w});
        ql.push_back({1'b1, ^w});
`endif
    endtask

    // Mid-cycle monitor: check current outputs, then book any transfer
    // that will happen at the coming rising edge.
    always @(negedge clk) begin
        logic [1:0] e;
        chk("ready_m", rdy_m, qm.size() <= 1);
        chk("valid_m", sv_m, qm.size() > 0);
        if (sv_m && qm.size() > 0) begin
            e = qm.pop_front();
            chk("bit_m", so_m, e[0]);
            chk("done_m", dn_m, e[1]);
        end else begin
            chk("idle_m", {so_m, dn_m}, 2'b00);
        end
        chk("ready_l", rdy_l, ql.size() <= 1);
        chk("valid_l", sv_l, ql.size() > 0);
        if (sv_l && ql.size() > 0) begin
            e = ql.pop_front();
            chk("bit_l", so_l, e[0]);
            chk("done_l", dn_l, e[1]);
        end else begin
            chk("idle_l", {so_l, dn_l}, 2'b00);
        end
        if (rst && din_valid && rdy_m) push_word(din);
    end

    task automatic send(input logic [W-1:0] w);
        bit ok = 0;
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy_m) begin
                ok = 1;
                break;
            end
        end
        chk("send_timeout", ok, 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_sout", so_m, 0);
        chk("rst_valid", sv_m, 0);
        chk("rst_done", dn_m, 0);
        chk("rst_ready", rdy_m, 1);
        idle(2);
        rst = 1'b1;
        idle(2);

        send(8'hE5);
        idle(12);
        send(8'h01);
        idle(12);

        // Second word held from the start of the first: no gap allowed.
        send(8'hF0);
        din       = 8'h0F;
        din_valid = 1'b1;
        idle(3);
        chk("held_ignored", qm.size() > 1, 1);
        send(8'h0F);
        idle(20);

        send(8'h55);
        din       = 8'hAA;
        din_valid = 1'b1;
        send(8'hAA);
        idle(20);

        send(8'h07);
        send(8'h03);
        idle(20);

        // Reset in flight after three bits of 8'hFF.
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        qm.delete();
        ql.delete();
        #1;
        chk("mid_rst_sout", so_m, 0);
        chk("mid_rst_valid", sv_m, 0);
        chk("mid_rst_done", dn_m, 0);
        chk("mid_rst_ready", rdy_m, 1);
        idle(2);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", rdy_m, 1);
        idle(15);

        for (int k = 0; k < 20; k++) begin
            send(W'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 10));
        end
        idle(25);
        chk("drained_m", qm.size(), 0);
        chk("drained_l", ql.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, as the number of data bits per word (legal range 2..16).
REQ-002 The block SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 shifted first.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 The block SHALL have port din_valid  input  1  din holds a word to transfer.
REQ-007 The block SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-008 The block SHALL have port sout  output  1  serial bit stream, registered.
REQ-009 The block SHALL have port sout_valid  output  1  sout carries a meaningful bit this cycle, registered.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking the final bit of a word, registered.

Function
REQ-011 Transfer SHALL occur on a rising edge where din_valid and din_ready are both 1; din SHALL be captured into the shift register at that edge.
REQ-012 The state machine SHALL have states IDLE, SHIFT and (PARITY_EN only) PAR.
REQ-013 In IDLE: din_ready=1, sout=0, sout_valid=0, done=0; transfer -> SHIFT.
REQ-014 The first data bit SHALL appear on sout with sout_valid=1 in the cycle after the transfer edge (latency 1).
REQ-015 In SHIFT, exactly one bit SHALL be presented per cycle for WIDTH consecutive cycles, and a bit counter SHALL count 0..WIDTH-1.
REQ-016 din_ready SHALL be 1 only in IDLE and in the cycle presenting the final bit of the word (last data bit, or parity bit when PARITY_EN).
REQ-017 A transfer during the final-bit cycle SHALL start the next word with no gap: first bit of the new word in the immediately following cycle, state SHIFT.
REQ-018 With no transfer during the final-bit cycle, the FSM SHALL return to IDLE and sout/sout_valid SHALL drop to 0 the next cycle.
REQ-019 done SHALL be 1 exactly in the final-bit cycle of each word and 0 otherwise.
REQ-020 din_valid asserted while din_ready=0 SHALL be ignored without side effects; the source holds din/din_valid until transfer.

Reset
REQ-021 rst=0 SHALL force, asynchronously, state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, done=0; din_ready=1 follows from IDLE.
REQ-022 Reset during SHIFT or PAR SHALL discard the word in flight; no further bits of it SHALL be emitted after reset release.

Configuration
REQ-023 Macro PISO_PARITY_EN SHALL control the parity feature.
REQ-024 With PISO_PARITY_EN defined, after the WIDTH data bits the FSM SHALL enter PAR for one cycle presenting the even-parity bit (XOR of the captured word) with sout_valid=1, and done and din_ready SHALL move to that cycle.
REQ-025 Without PISO_PARITY_EN, state PAR and the parity logic SHALL not exist and a word SHALL occupy exactly WIDTH cycles.

Structure
REQ-026 A shared package piso_pkg SHALL hold the state encoding constants (IDLE, SHIFT, PAR) and the default WIDTH.
REQ-027 The bit counter SHALL be one sub-module, piso_bit_cnt (clear, enable, terminal-count output), and no other sub-modules are needed.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, din=8'hE5 transferred at edge 0 -> sout=1,1,1,0,0,1,0,1 in cycles 1..8, sout_valid=1 in cycles 1..8, done=1 only in cycle 8, sout_valid=0 in cycle 9.
REQ-029 Back-to-back 8'hF0 then 8'h0F, with the second transfer in the done cycle -> 16 contiguous valid bits 1111000000001111, no gap, done in cycles 8 and 16.
REQ-030 MSB_FIRST=0, din=8'h01 -> sout=1 in cycle 1, then 0 for cycles 2..8.
REQ-031 PISO_PARITY_EN, din=8'h07 -> 8 data bits then parity bit 1 in cycle 9, done only in cycle 9; din=8'h03 -> parity bit 0.
REQ-032 Reset asserted after the 3rd bit of 8'hFF -> sout=0 and sout_valid=0 immediately, din_ready=1 after release, no remaining bits of 8'hFF emitted.
REQ-033 din_valid held high with din=8'hAA during a word in flight -> no effect until the final-bit cycle, then 8'hAA transferred exactly once.
